// File: rtl/s2p_pkg.sv
// rtl/s2p_pkg.sv - shared types and constants for the serial-to-parallel receiver
package s2p_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFTING,
    FULL,
    OVER
  } s2p_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with history flop and rising-edge detect
module sync_edge
  import s2p_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;

endmodule

// File: rtl/s2p_receiver.sv
// rtl/s2p_receiver.sv - oversampling shift-register link receiver with latch strobe
module s2p_receiver
  import s2p_pkg::*;
#(
  parameter int BIT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sclk,
  input  logic                             sclrn,
  input  logic                             sin,
  input  logic                             EN,
  output logic [BIT_WIDTH-1:0]             par_out,
  output logic                             valid,
  output logic                             err_short,
  output logic                             err_long,
  output logic [$clog2(BIT_WIDTH+2)-1:0]   bit_cnt
);

  localparam int CW = $clog2(BIT_WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(BIT_WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BIT_WIDTH + 1);

  logic sclk_s, sclk_rise;
  logic en_s, en_rise;
  logic sclrn_s, sclrn_rise;
  logic unused_sync;

  sync_edge #(.RESET_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .rst(rst), .async_i(sclk), .level_o(sclk_s), .rise_o(sclk_rise)
  );

  sync_edge #(.RESET_VAL(1'b1)) u_sync_en (
    .clk(clk), .rst(rst), .async_i(EN), .level_o(en_s), .rise_o(en_rise)
  );

  sync_edge #(.RESET_VAL(1'b1)) u_sync_sclrn (
    .clk(clk), .rst(rst), .async_i(sclrn), .level_o(sclrn_s), .rise_o(sclrn_rise)
  );

  assign unused_sync = ^{sclk_s, en_s, sclrn_rise};

  // Same depth as the sclk synchronizer so the sampled bit lines up with the detected edge.
  logic [SYNC_STAGES-1:0] sin_q;
  logic                   sin_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_q <= '0;
    end else begin
      sin_q <= {sin_q[SYNC_STAGES-2:0], sin};
    end
  end

  assign sin_s = sin_q[SYNC_STAGES-1];

  logic [BIT_WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] par_q;
  logic                 valid_q, err_short_q, err_long_q;
  s2p_state_t           state_q;
  logic                 clr, shift;

  assign clr   = ~sclrn_s;
  assign shift = sclk_rise & ~clr;

  // Clear wins over shift; the latch below then sees the resolved value and count.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift) begin
      sr_d = {sin_s, sr_q[BIT_WIDTH-1:1]};
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      par_q       <= '0;
      valid_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      state_q     <= IDLE;
    end else begin
      valid_q <= 1'b0;
      sr_q    <= sr_d;
      if (en_rise) begin
        par_q       <= sr_d;
        err_short_q <= (cnt_d < CNT_FULL);
        err_long_q  <= (cnt_d > CNT_FULL);
        valid_q     <= 1'b1;
        cnt_q       <= '0;
        state_q     <= IDLE;
      end else begin
        cnt_q <= cnt_d;
        if (clr) begin
          state_q <= IDLE;
        end else if (shift) begin
          case (state_q)
            IDLE:     state_q <= (cnt_d == CNT_FULL) ? FULL : SHIFTING;
            SHIFTING: if (cnt_d == CNT_FULL) state_q <= FULL;
            FULL:     state_q <= OVER;
            OVER:     state_q <= OVER;
            default:  state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign par_out   = par_q;
  assign valid     = valid_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign bit_cnt   = cnt_q;

endmodule

// File: doc/s2p_receiver.md
# s2p_receiver

Serial-to-parallel receiver for the board's shift-register link: the far end of the parallel-to-serial transmitter that drives `sclk`/`sout`/`EN`. It oversamples the asynchronous serial lines in the local clock domain, shifts in data LSB-first on each `sclk` rising edge, and captures the word on the `EN` rising edge, much like a '595 storage latch. It then presents the word with a one-cycle valid pulse and frame-length error flags. It is used for loopback testing of the transmitter and for boards where the FPGA is the serial sink.

## Interface
- `BIT_WIDTH`, default 8: data bits per frame.
- `clk`  in  1  local clock; must be at least 4x the transmitter's shift clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `sclk`  in  1  serial clock, asynchronous, idles high, data sampled on rising edge.
- `sclrn`  in  1  asynchronous active-low clear of the shift register, level-sensitive after sync.
- `sin`  in  1  serial data, asynchronous, stable around `sclk` rising edge.
- `EN`  in  1  latch strobe, asynchronous, idles high; rising edge latches the frame.
- `par_out`  out  BIT_WIDTH  last latched word; first received bit at bit 0.
- `valid`  out  1  one-cycle pulse when `par_out` updates.
- `err_short`  out  1  last latched frame had fewer than BIT_WIDTH bits; held until the next latch.
- `err_long`  out  1  last latched frame had more than BIT_WIDTH bits; held until the next latch.
- `bit_cnt`  out  $clog2(BIT_WIDTH+2)  bits received in the current frame, saturating at BIT_WIDTH+1.

## Operation
- Input conditioning: `sclk`, `sin`, `sclrn`, `EN` each pass through a 2-flop synchronizer plus one history flop. `sin` is delayed identically to `sclk`, so the sampled bit is the value aligned with the edge.
- Synchronizer reset values: `sclk`, `EN`, `sclrn` chains reset to 1, so no spurious edge occurs after reset. `sin` chain resets to 0.
- Shift edge (synced `sclk` 0→1): `sr <= {sin_s, sr[BIT_WIDTH-1:1]}`; `bit_cnt` increments and saturates at BIT_WIDTH+1.
- Latch edge (synced `EN` 0→1):
  - `par_out <= sr`
  - `err_short <= (bit_cnt < BIT_WIDTH)`
  - `err_long <= (bit_cnt > BIT_WIDTH)`
  - `valid` pulses for one cycle
  - `bit_cnt <= 0`; FSM returns to IDLE
  - `sr` is not cleared.
- FSM, states in package enum:
  - IDLE (cnt=0): shift → SHIFTING.
  - SHIFTING (0<cnt<W): cnt reaches W → FULL.
  - FULL (cnt=W): further shift → OVER.
  - OVER (cnt=W+1): shifting continues and the oldest bits fall off.
  - Any state: latch → IDLE.
- Simultaneous events in the same cycle are resolved in this order:
  1. Synced `sclrn` low clears `sr` and `bit_cnt`.
  2. Otherwise the shift is applied.
  3. The latch captures the post-clear/post-shift value and count.
  - Consequence: clear+latch yields `par_out`=0 and `err_short`=1.
- While synced `sclrn` is low, shift edges are ignored.
- Reset (any time, including mid-frame): all state is cleared; `par_out`=0, `valid`=0, `err_short`=0, `err_long`=0, `bit_cnt`=0, FSM=IDLE.

## Timing
- Pin-to-action latency is 3 `clk` rising edges (2 sync + 1 edge detect). The register update lands on that 3rd edge.
- `valid` is asserted in the cycle after the latch edge is detected, for exactly 1 cycle. `par_out` and the error flags are stable from that cycle onward.
- Minimum `sclk` high and low time is 2 `clk` periods. Minimum `EN` high and low time is 2 `clk` periods.
- No backpressure: a new latch overwrites `par_out` regardless of consumer.

## Structure
- Package `s2p_pkg`: FSM state enum `s2p_state_t` (IDLE, SHIFTING, FULL, OVER) and a `SYNC_STAGES = 2` constant.
- Sub-module `sync_edge` (parameter reset value; outputs synced level and rising-edge pulse), instantiated for `sclk`, `EN`, `sclrn`. `sin` uses a plain delay chain of matching depth.

## Test plan
- Reset, then 8 `sclk` pulses carrying 0xA5 LSB-first, then an `EN` rise → `par_out`=0xA5, `valid` high exactly 1 cycle, `err_short`=0, `err_long`=0, `bit_cnt` back to 0.
- 7 pulses of bits 1,0,1,1,0,0,1, then `EN` → `par_out`[7:1]=0b1001101, `err_short`=1, `err_long`=0.
- 9 pulses of 0x1FF-pattern with the first bit 0 (bits 0,1,1,1,1,1,1,1,1), then `EN` → `par_out`=0xFF, `err_long`=1, `bit_cnt` saturated at 9 before the latch.
- 4 pulses, `sclrn` low for 3 cycles, then 8 pulses of 0x3C and `EN` → `par_out`=0x3C, no errors.
- `rst` asserted after 5 bits → all outputs 0 immediately, and no `valid` follows when `rst` deasserts with `sclk`/`EN` still high.
- 8th `sclk` rise and `EN` rise arrive in the same `clk` cycle with 0x81 → `par_out`=0x81, no errors.
